trace_dump_engine: RTL and testbench

TRACE_DUMP_ENGINE -- requirements
Module: trace_dump_engine

---
 rtl/trace_dump_pkg.sv | 19 +
 rtl/trace_byte_serializer.sv | 46 ++++
 rtl/trace_dump_engine.sv | 153 +++++++++++++++
 tb/tb_trace_dump_engine.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_dump_pkg.sv
// rtl/trace_dump_pkg.sv - shared state encoding and stream constants for the trace dump engine
package trace_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_RD_REQ,
    ST_RD_CAP,
    ST_SEND,
    ST_DONE
  } dump_state_t;

  localparam int BYTES_PER_ENTRY = 8;
  localparam int LEN_BITS        = 4;

  localparam logic [7:0] HDR_MAGIC0 = 8'hA5;
  localparam logic [7:0] HDR_MAGIC1 = 8'h5A;

endpackage

// File: rtl/trace_byte_serializer.sv
// rtl/trace_byte_serializer.sv - loads up to 8 bytes and shifts them out LSB-first under valid/ready
module trace_byte_serializer
  import trace_dump_pkg::*;
(
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush,
  input  logic                           load,
  input  logic [LEN_BITS-1:0]            load_len,
  input  logic [8*BYTES_PER_ENTRY-1:0]   load_data,
  output logic [7:0]                     tx_data,
  output logic                           tx_valid,
  input  logic                           tx_ready,
  output logic                           last
);

  logic [8*BYTES_PER_ENTRY-1:0] shift_q;
  logic [LEN_BITS-1:0]          remain_q;
  logic                         fire;

  assign fire    = tx_valid & tx_ready;
  assign last    = fire & (remain_q == LEN_BITS'(1));
  assign tx_data = shift_q[7:0];

  // Shift register: the current byte is held until accepted, so stalls never disturb tx_data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q  <= '0;
      remain_q <= '0;
      tx_valid <= 1'b0;
    end else if (flush) begin
      shift_q  <= '0;
      remain_q <= '0;
      tx_valid <= 1'b0;
    end else if (load) begin
      shift_q  <= load_data;
      remain_q <= load_len;
      tx_valid <= (load_len != '0);
    end else if (fire) begin
      shift_q  <= {8'h00, shift_q[8*BYTES_PER_ENTRY-1:8]};
      remain_q <= remain_q - LEN_BITS'(1);
      tx_valid <= (remain_q != LEN_BITS'(1));
    end
  end

endmodule

// File: rtl/trace_dump_engine.sv
// rtl/trace_dump_engine.sv - walks a frozen trace buffer oldest-first and streams it as bytes; TRACE_DUMP_HEADER_EN adds a 4-byte header
module trace_dump_engine
  import trace_dump_pkg::*;
#(
  parameter int TRACE_DEPTH = 64,
  parameter int PTR_BITS    = $clog2(TRACE_DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                trace_triggered_i,
  input  logic [PTR_BITS-1:0] trace_wr_ptr_i,
  output logic [PTR_BITS-1:0] trace_rd_addr_o,
  input  logic [31:0]         trace_rd_pc_i,
  input  logic [31:0]         trace_rd_instr_i,
  input  logic                dump_start_i,
  input  logic                auto_dump_en_i,
  input  logic                abort_i,
  output logic [7:0]          tx_data_o,
  output logic                tx_valid_o,
  input  logic                tx_ready_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [PTR_BITS:0]   entry_idx_o
);

  localparam int IDX_BITS = PTR_BITS + 1;

  if (TRACE_DEPTH < 2 || TRACE_DEPTH > 256 || (TRACE_DEPTH & (TRACE_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("trace_dump_engine: TRACE_DEPTH must be a power of two in 2..256");
  end

`ifdef TRACE_DUMP_HEADER_EN
  localparam int         HDR_BYTES  = 4;
  localparam logic [8:0] DEPTH9     = 9'(TRACE_DEPTH);
  localparam logic [7:0] DEPTH_BYTE = DEPTH9[7:0];
`endif

  dump_state_t               state_q;
  logic [PTR_BITS-1:0]       base_q;
  logic [IDX_BITS-1:0]       entry_idx_q;
  logic [IDX_BITS-1:0]       next_idx;
  logic                      trig_q;
  logic                      trig_rise;
  logic                      start;
  logic                      busy_q;
  logic                      done_q;
  logic                      ser_load;
  logic                      ser_last;
  logic [LEN_BITS-1:0]       ser_len;
  logic [8*BYTES_PER_ENTRY-1:0] ser_data;

  assign trig_rise = trace_triggered_i & ~trig_q;
  assign start     = (dump_start_i | (auto_dump_en_i & trig_rise)) & trace_triggered_i;
  assign next_idx  = entry_idx_q + IDX_BITS'(1);

  assign trace_rd_addr_o = (state_q == ST_IDLE) ? '0 : base_q + entry_idx_q[PTR_BITS-1:0];
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign entry_idx_o     = entry_idx_q;

  // Serializer load: entry bytes when the read data is captured, header bytes on the start edge.
  always_comb begin
    ser_load = 1'b0;
    ser_len  = LEN_BITS'(BYTES_PER_ENTRY);
    ser_data = {trace_rd_instr_i, trace_rd_pc_i};
    if (!abort_i) begin
      if (state_q == ST_RD_CAP) begin
        ser_load = 1'b1;
      end
`ifdef TRACE_DUMP_HEADER_EN
      else if (state_q == ST_IDLE && start) begin
        ser_load = 1'b1;
        ser_len  = LEN_BITS'(HDR_BYTES);
        ser_data = {32'h0, 8'(trace_wr_ptr_i), DEPTH_BYTE, HDR_MAGIC1, HDR_MAGIC0};
      end
`endif
    end
  end

  // Dump sequencer: snapshot the oldest slot, then read/capture/send one entry at a time.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      entry_idx_q <= '0;
      trig_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      trig_q <= trace_triggered_i;
      done_q <= 1'b0;
      if (abort_i) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              base_q      <= trace_wr_ptr_i;
              entry_idx_q <= '0;
              busy_q      <= 1'b1;
`ifdef TRACE_DUMP_HEADER_EN
              state_q     <= ST_HDR;
`else
              state_q     <= ST_RD_REQ;
`endif
            end
          end
`ifdef TRACE_DUMP_HEADER_EN
          ST_HDR: begin
            if (ser_last) state_q <= ST_RD_REQ;
          end
`endif
          ST_RD_REQ: state_q <= ST_RD_CAP;
          ST_RD_CAP: state_q <= ST_SEND;
          ST_SEND: begin
            if (ser_last) begin
              entry_idx_q <= next_idx;
              if (next_idx < IDX_BITS'(TRACE_DEPTH)) begin
                state_q <= ST_RD_REQ;
              end else begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  trace_byte_serializer u_ser (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush     (abort_i),
    .load      (ser_load),
    .load_len  (ser_len),
    .load_data (ser_data),
    .tx_data   (tx_data_o),
    .tx_valid  (tx_valid_o),
    .tx_ready  (tx_ready_i),
    .last      (ser_last)
  );

endmodule

// File: tb/tb_trace_dump_engine.sv
// tb/tb_trace_dump_engine.sv - directed self-checking bench for trace_dump_engine at TRACE_DEPTH=4
module tb_trace_dump_engine;

`ifdef TRACE_DUMP_HEADER_EN
  localparam int HDR_N = 4;
`else
  localparam int HDR_N = 0;
`endif
  localparam int TOTAL   = HDR_N + 32;
  localparam int EXP_CYC = 41 + HDR_N;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        trace_triggered = 1'b0;
  logic [1:0]  trace_wr_ptr = '0;
  logic [1:0]  trace_rd_addr;
  logic [31:0] trace_rd_pc = '0;
  logic [31:0] trace_rd_instr = '0;
  logic        dump_start = 1'b0;
  logic        auto_dump_en = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy;
  logic        done;
  logic [2:0]  entry_idx;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] got [0:63];

  trace_dump_engine #(.TRACE_DEPTH(4)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .trace_triggered_i (trace_triggered),
    .trace_wr_ptr_i    (trace_wr_ptr),
    .trace_rd_addr_o   (trace_rd_addr),
    .trace_rd_pc_i     (trace_rd_pc),
    .trace_rd_instr_i  (trace_rd_instr),
    .dump_start_i      (dump_start),
    .auto_dump_en_i    (auto_dump_en),
    .abort_i           (abort),
    .tx_data_o         (tx_data),
    .tx_valid_o        (tx_valid),
    .tx_ready_i        (tx_ready),
    .busy_o            (busy),
    .done_o            (done),
    .entry_idx_o       (entry_idx)
  );

  always #5 clk_i = ~clk_i;

  // Trace RAM model with one cycle of read latency.
  always @(posedge clk_i) begin
    trace_rd_pc    <= 32'h1000 + (32'(trace_rd_addr) << 2);
    trace_rd_instr <= 32'h13 + 32'(trace_rd_addr);
  end

  function automatic logic [7:0] exp_byte(input int base, input int n);
    int m, e, b, slot;
    logic [31:0] w;
    m = n;
`ifdef TRACE_DUMP_HEADER_EN
    if (m == 0) return 8'hA5;
    if (m == 1) return 8'h5A;
    if (m == 2) return 8'h04;
    if (m == 3) return 8'(base);
    m = m - 4;
`endif
    e    = m / 8;
    b    = m % 8;
    slot = (base + e) % 4;
    w    = (b < 4) ? 32'h1000 + 32'(4 * slot) : 32'h13 + 32'(slot);
    return w[8*(b%4) +: 8];
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_dump(input logic [1:0] ptr);
    trace_wr_ptr = ptr;
    dump_start   = 1'b1;
    step();
    dump_start   = 1'b0;
  endtask

  task automatic collect(input int base, input bit toggle, input int restart_at,
                         output int nbytes, output int ncyc, output int ndone);
    logic [7:0] pdata, e;
    bit pvalid, pready, fin;
    nbytes = 0; ncyc = 0; ndone = 0;
    pvalid = 0; pready = 1; pdata = '0; fin = 0;
    for (int k = 0; k < 600 && !fin; k++) begin
      tx_ready   = toggle ? (k % 2 == 0) : 1'b1;
      dump_start = (k == restart_at);
      if (!busy) begin
        fin = 1;
      end else begin
        ncyc++;
        if (pvalid && !pready) begin
          n_vec++;
          if (tx_valid !== 1'b1 || tx_data !== pdata) begin
            n_err++;
            $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h", tx_valid, tx_data, pdata);
          end
        end
        if (done) begin
          ndone++;
          n_vec++;
          if (nbytes !== TOTAL) begin
            n_err++;
            $display("FAIL done_timing: done with %0d bytes sent, required %0d", nbytes, TOTAL);
          end
        end
        if (tx_valid && tx_ready) begin
          e = exp_byte(base, nbytes);
          n_vec++;
          if (tx_data !== e) begin
            n_err++;
            $display("FAIL byte_%0d: got %h, required %h", nbytes, tx_data, e);
          end
          if (nbytes < 64) got[nbytes] = tx_data;
          nbytes++;
        end
        pvalid = tx_valid; pready = tx_ready; pdata = tx_data;
        step();
      end
    end
    dump_start = 1'b0;
    tx_ready   = 1'b1;
    if (!fin) begin
      n_vec++;
      n_err++;
      $display("FAIL dump_timeout: busy still %b after 600 cycles, required 0", busy);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    step();
    n_vec++; if (tx_valid !== 1'b0)      begin n_err++; $display("FAIL rst_valid: got %b, required 0", tx_valid); end
    n_vec++; if (tx_data !== 8'h00)      begin n_err++; $display("FAIL rst_data: got %h, required 00", tx_data); end
    n_vec++; if (busy !== 1'b0)          begin n_err++; $display("FAIL rst_busy: got %b, required 0", busy); end
    n_vec++; if (done !== 1'b0)          begin n_err++; $display("FAIL rst_done: got %b, required 0", done); end
    n_vec++; if (entry_idx !== 3'd0)     begin n_err++; $display("FAIL rst_idx: got %0d, required 0", entry_idx); end
    n_vec++; if (trace_rd_addr !== 2'd0) begin n_err++; $display("FAIL rst_addr: got %0d, required 0", trace_rd_addr); end
  endtask

  task automatic test_ignored_start();
    trace_triggered = 1'b0;
    step();
    start_dump(2'd1);
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (busy !== 1'b0 || tx_valid !== 1'b0) begin
        n_err++;
        $display("FAIL untriggered_start: busy=%b valid=%b, required 0 0", busy, tx_valid);
      end
      step();
    end
  endtask

  task automatic test_full_dump();
    int nb, nc, nd;
    trace_triggered = 1'b1;
    step();
    start_dump(2'd2);
    collect(2, 1'b0, -1, nb, nc, nd);
    n_vec++; if (nb !== TOTAL)            begin n_err++; $display("FAIL full_bytes: got %0d, required %0d", nb, TOTAL); end
    n_vec++; if (nc !== EXP_CYC)          begin n_err++; $display("FAIL full_cycles: got %0d, required %0d", nc, EXP_CYC); end
    n_vec++; if (nd !== 1)                begin n_err++; $display("FAIL full_done_count: got %0d, required 1", nd); end
    n_vec++; if (got[HDR_N] !== 8'h08)    begin n_err++; $display("FAIL first_entry_byte: got %h, required 08", got[HDR_N]); end
    n_vec++; if (got[HDR_N+4] !== 8'h15)  begin n_err++; $display("FAIL first_instr_byte: got %h, required 15", got[HDR_N+4]); end
    n_vec++; if (entry_idx !== 3'd4)      begin n_err++; $display("FAIL final_idx: got %0d, required 4", entry_idx); end
    n_vec++; if (trace_rd_addr !== 2'd0)  begin n_err++; $display("FAIL idle_addr: got %0d, required 0", trace_rd_addr); end
  endtask

  task automatic test_stall_dump();
    int nb, nc, nd;
    start_dump(2'd2);
    collect(2, 1'b1, -1, nb, nc, nd);
    n_vec++; if (nb !== TOTAL)      begin n_err++; $display("FAIL stall_bytes: got %0d, required %0d", nb, TOTAL); end
    n_vec++; if (nd !== 1)          begin n_err++; $display("FAIL stall_done_count: got %0d, required 1", nd); end
    n_vec++; if (nc <= EXP_CYC)     begin n_err++; $display("FAIL stall_cycles: got %0d, required more than %0d", nc, EXP_CYC); end
  endtask

  task automatic test_auto_start();
    int nb, nc, nd;
    trace_triggered = 1'b0;
    auto_dump_en    = 1'b1;
    step();
    trace_wr_ptr    = 2'd1;
    trace_triggered = 1'b1;
    step();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL auto_start: busy=%b, required 1", busy); end
    collect(1, 1'b0, 15, nb, nc, nd);
    auto_dump_en = 1'b0;
    n_vec++; if (nb !== TOTAL)   begin n_err++; $display("FAIL auto_bytes: got %0d, required %0d", nb, TOTAL); end
    n_vec++; if (nc !== EXP_CYC) begin n_err++; $display("FAIL busy_restart_cycles: got %0d, required %0d", nc, EXP_CYC); end
    n_vec++; if (nd !== 1)       begin n_err++; $display("FAIL auto_done_count: got %0d, required 1", nd); end
  endtask

  task automatic test_abort();
    int cnt, nb, nc, nd;
    start_dump(2'd2);
    cnt = 0;
    for (int k = 0; k < 200 && cnt < 13; k++) begin
      if (tx_valid && tx_ready) cnt++;
      step();
    end
    n_vec++; if (cnt !== 13) begin n_err++; $display("FAIL abort_reach: got %0d bytes, required 13", cnt); end
    abort      = 1'b1;
    tx_ready   = 1'b0;
    dump_start = 1'b1;
    step();
    abort      = 1'b0;
    dump_start = 1'b0;
    tx_ready   = 1'b1;
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL abort_valid: got %b, required 0", tx_valid); end
    n_vec++; if (busy !== 1'b0)     begin n_err++; $display("FAIL abort_busy: got %b, required 0", busy); end
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL abort_quiet: done=%b busy=%b, required 0 0", done, busy);
      end
      step();
    end
    start_dump(2'd2);
    n_vec++; if (entry_idx !== 3'd0) begin n_err++; $display("FAIL restart_idx: got %0d, required 0", entry_idx); end
    collect(2, 1'b0, -1, nb, nc, nd);
    n_vec++; if (nb !== TOTAL) begin n_err++; $display("FAIL restart_bytes: got %0d, required %0d", nb, TOTAL); end
    n_vec++; if (nd !== 1)     begin n_err++; $display("FAIL restart_done_count: got %0d, required 1", nd); end
  endtask

  task automatic test_reset_mid();
    start_dump(2'd2);
    for (int k = 0; k < 20 && !tx_valid; k++) step();
    n_vec++; if (tx_valid !== 1'b1) begin n_err++; $display("FAIL midrst_send: valid=%b, required 1", tx_valid); end
    #3;
    rst_i = 1'b1;
    #1;
    n_vec++; if (tx_valid !== 1'b0)      begin n_err++; $display("FAIL midrst_valid: got %b, required 0", tx_valid); end
    n_vec++; if (tx_data !== 8'h00)      begin n_err++; $display("FAIL midrst_data: got %h, required 00", tx_data); end
    n_vec++; if (busy !== 1'b0)          begin n_err++; $display("FAIL midrst_busy: got %b, required 0", busy); end
    n_vec++; if (entry_idx !== 3'd0)     begin n_err++; $display("FAIL midrst_idx: got %0d, required 0", entry_idx); end
    n_vec++; if (trace_rd_addr !== 2'd0) begin n_err++; $display("FAIL midrst_addr: got %0d, required 0", trace_rd_addr); end
    step();
    rst_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      n_vec++;
      if (busy !== 1'b0 || tx_valid !== 1'b0) begin
        n_err++;
        $display("FAIL midrst_resume: busy=%b valid=%b, required 0 0", busy, tx_valid);
      end
    end
  endtask

`ifdef TRACE_DUMP_HEADER_EN
  task automatic test_header();
    int nb, nc, nd;
    start_dump(2'd3);
    collect(3, 1'b0, -1, nb, nc, nd);
    n_vec++; if (got[0] !== 8'hA5) begin n_err++; $display("FAIL hdr_magic0: got %h, required a5", got[0]); end
    n_vec++; if (got[1] !== 8'h5A) begin n_err++; $display("FAIL hdr_magic1: got %h, required 5a", got[1]); end
    n_vec++; if (got[2] !== 8'h04) begin n_err++; $display("FAIL hdr_depth: got %h, required 04", got[2]); end
    n_vec++; if (got[3] !== 8'h03) begin n_err++; $display("FAIL hdr_base: got %h, required 03", got[3]); end
    n_vec++; if (nb !== TOTAL)     begin n_err++; $display("FAIL hdr_bytes: got %0d, required %0d", nb, TOTAL); end
  endtask
`endif

  initial begin
    test_reset();
    test_ignored_start();
    test_full_dump();
    test_stall_dump();
    test_auto_start();
    test_abort();
    test_reset_mid();
`ifdef TRACE_DUMP_HEADER_EN
    trace_triggered = 1'b1;
    step();
    test_header();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
